vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the board clock. Provides the `hCount`/`vCount` pixel coordinates and the `bright` window consumed by the game renderer. Also drives the monitor `hSync`/`vSync` pins and a once-per-frame `frame_tick` for slow game-logic stepping. It is the producer end of the pixel-coordinate interface that the renderer samples.

## Interface
Parameters:
- `CLK_DIV`, 4: board clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range 1..16
- `H_TOTAL`, 800: pixel clocks per line
- `H_SYNC`, 96: hSync low width, starting at hCount 0
- `H_VIS_START`, 144: first visible hCount
- `H_VIS_END`, 784: first non-visible hCount after the active region
- `V_TOTAL`, 525: lines per frame
- `V_SYNC`, 2: vSync low width in lines, starting at vCount 0
- `V_VIS_START`, 35: first visible vCount
- `V_VIS_END`, 515: first non-visible vCount after the active region

Ports:
- `clk` in 1: single clock for all logic
- `rst` in 1: reset, asynchronous and active-high
- `hCount` out 10: horizontal pixel counter, 0..H_TOTAL-1
- `vCount` out 10: vertical line counter, 0..V_TOTAL-1
- `hSync` out 1: active-low horizontal sync
- `vSync` out 1: active-low vertical sync
- `bright` out 1: high inside the visible window
- `pix_en` out 1: one-clk strobe marking the pixel step
- `frame_tick` out 1: one-clk pulse per frame

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div_cnt == CLK_DIV-1), decoded combinationally.
  - If CLK_DIV==1, `pix_en` is constant 1.
- On a clk edge with `pix_en` high, the raster counters advance:
  - `hCount` increments.
  - At H_TOTAL-1, `hCount` wraps to 0 and `vCount` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Decodes, combinational from the registered counters (zero latency):
  - `hSync` = !(hCount < H_SYNC)
  - `vSync` = !(vCount < V_SYNC)
  - `bright` = (H_VIS_START <= hCount < H_VIS_END) && (V_VIS_START <= vCount < V_VIS_END)
- `frame_tick` is registered. It is set high on the edge where both counters wrap to 0 and cleared on the next clk edge, so it is exactly one clk wide.
- Arithmetic: counters are 10-bit unsigned; the parameter ranges guarantee no overflow. Comparisons are unsigned.

## Timing
- Reset values while `rst` is high, forced asynchronously:
  - counters: `div_cnt`=0, `hCount`=0, `vCount`=0
  - registered outputs: `frame_tick`=0
  - decoded outputs follow from the counters: `hSync`=0, `vSync`=0, `bright`=0
  - `pix_en` = (CLK_DIV==1)
- After `rst` falls, with CLK_DIV=4:
  - `pix_en` is first high in the 4th clk cycle.
  - `hCount` becomes 1 at the 4th rising edge.
  - `pix_en` then repeats every 4 clks.
- Line period: H_TOTAL*CLK_DIV = 3200 clks.
- Frame period: 800*525*4 = 1,680,000 clks. `frame_tick` pulses once per frame period.
- First `frame_tick` appears 1,680,000 clks after reset release, in the cycle where counters read (0,0).
- Reset asserted mid-frame zeroes everything immediately, with no glitch pulse on `frame_tick`. Timing restarts from (0,0) on release.
- No input handshake; consumers sample `hCount`, `vCount` and `bright` on any clk.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the default timing constants (H_*/V_* values above)
  - the 10-bit coordinate width constant, also used by the renderer for `hCount`/`vCount`
- One sub-module, `mod_n_counter`: parameterised modulus, enable in, wrap strobe out. It is instantiated three times: prescaler, horizontal, and vertical. Each stage's enable is the previous stage's wrap strobe, ANDed with `pix_en` for the vertical stage.
- Sync and bright decode plus the `frame_tick` register stay in the top level.

## Test plan
- Reset/prescale: hold `rst` 5 clks, release -> all outputs at reset values; `pix_en` high on clks 3, 7, 11 after release; `hCount` reads 1, 2, 3 after those edges.
- Horizontal wrap: run 3200 clks -> `hCount` goes 799 -> 0, `vCount` goes 0 -> 1 on the same edge; `hSync` low exactly 96*4=384 clks per line.
- Bright window: at vCount=35, `bright` rises when hCount=144 and falls at hCount=784; `bright`=0 for every pixel at vCount=34 and vCount=515.
- Frame: run 2 frames -> `frame_tick` asserted exactly twice, each 1 clk wide, 1,680,000 clks apart; `vSync` low for 2*3200=6400 clks per frame.
- Mid-frame reset: assert `rst` asynchronously (off clock edge) at hCount=400, vCount=200 -> counters read 0 before the next clk edge; `frame_tick` stays 0; after release the waveform matches the first scenario.
- CLK_DIV=1 build: `pix_en` constant 1; `hCount` increments every clk; frame period is 420,000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 raster numbers and the
// coordinate width the renderer also uses for hCount/vCount.
package vga_timing_pkg;
    localparam int unsigned COORD_W         = 10;
    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam int unsigned DEF_H_TOTAL     = 800;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_VIS_START = 144;
    localparam int unsigned DEF_H_VIS_END   = 784;
    localparam int unsigned DEF_V_TOTAL     = 525;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_VIS_START = 35;
    localparam int unsigned DEF_V_VIS_END   = 515;
endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate/sync bundle between the timing generator and its consumers.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;
    logic [COORD_W-1:0] hCount;
    logic [COORD_W-1:0] vCount;
    logic               hSync;
    logic               vSync;
    logic               bright;
    logic               pix_en;
    logic               frame_tick;

    modport master (output hCount, vCount, hSync, vSync, bright, pix_en, frame_tick);
    modport slave  (input  hCount, vCount, hSync, vSync, bright, pix_en, frame_tick);
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with enable; wrap is a combinational strobe on the
// enabled cycle in which the counter rolls from N-1 back to 0.
module mod_n_counter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: prescaler -> horizontal -> vertical counter chain,
// zero-latency sync/bright decode and a registered one-clk frame_tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_VIS_START = DEF_H_VIS_START,
    parameter int unsigned H_VIS_END   = DEF_H_VIS_END,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_VIS_START = DEF_V_VIS_START,
    parameter int unsigned V_VIS_END   = DEF_V_VIS_END
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);
    // 4 bits covers the full 1..16 divider range (count 0..15)
    localparam int unsigned DIV_W = 4;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] HV_START = COORD_W'(H_VIS_START);
    localparam logic [COORD_W-1:0] HV_END   = COORD_W'(H_VIS_END);
    localparam logic [COORD_W-1:0] VV_START = COORD_W'(V_VIS_START);
    localparam logic [COORD_W-1:0] VV_END   = COORD_W'(V_VIS_END);

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               div_wrap, h_wrap, v_wrap, pix_en;
    logic               frame_tick;

    mod_n_counter #(.N(CLK_DIV), .W(DIV_W)) u_prescale (
        .clk(clk), .rst(rst), .en(1'b1), .cnt(div_cnt), .wrap(div_wrap)
    );

    mod_n_counter #(.N(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk(clk), .rst(rst), .en(div_wrap), .cnt(h_cnt), .wrap(h_wrap)
    );

    mod_n_counter #(.N(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk(clk), .rst(rst), .en(h_wrap & pix_en), .cnt(v_cnt), .wrap(v_wrap)
    );

    // With CLK_DIV==1 the prescaler sits at 0 == DIV_LAST, so pix_en is constant 1
    assign pix_en = (div_cnt == DIV_LAST);

    // v_wrap is high exactly on the cycle before both counters return to (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_tick <= 1'b0;
        else
            frame_tick <= v_wrap;
    end

    assign vga.hCount     = h_cnt;
    assign vga.vCount     = v_cnt;
    assign vga.hSync      = !(h_cnt < HS_END);
    assign vga.vSync      = !(v_cnt < VS_END);
    assign vga.bright     = (h_cnt >= HV_START) && (h_cnt < HV_END) &&
                            (v_cnt >= VV_START) && (v_cnt < VV_END);
    assign vga.pix_en     = pix_en;
    assign vga.frame_tick = frame_tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized reset/run episodes on three builds (default timing, a small
// CLK_DIV=3 raster and a CLK_DIV=1 raster) checked against an arithmetic model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sm ();
    vga_timing_gen_if if_d1 ();

    vga_timing_gen u_def (.clk(clk), .rst(rst), .vga(if_def));

    vga_timing_gen #(
        .CLK_DIV(3), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
    ) u_sm (.clk(clk), .rst(rst), .vga(if_sm));

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
    ) u_d1 (.clk(clk), .rst(rst), .vga(if_d1));

    int n_vec = 0;
    int n_err = 0;

    // Rising edges seen since the last reset release
    int tc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) tc <= 0;
        else     tc <= tc + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at t=%0t tc=%0d: got %0d, expected %0d", tag, $time, tc, got, exp);
        end
    endtask

    // Expected raster position is just elapsed pixel steps folded into (h, v)
    task automatic check_dut(input string nm, input int d, input int ht, input int hs,
                             input int hvs, input int hve, input int vt, input int vs,
                             input int vvs, input int vve,
                             input int hc, input int vc, input int hsy, input int vsy,
                             input int br, input int pe, input int ft);
        int p, h, v;
        p = tc / d;
        h = p % ht;
        v = (p / ht) % vt;
        chk({nm, ".hCount"},     hc,  h);
        chk({nm, ".vCount"},     vc,  v);
        chk({nm, ".hSync"},      hsy, int'(h >= hs));
        chk({nm, ".vSync"},      vsy, int'(v >= vs));
        chk({nm, ".bright"},     br,  int'(h >= hvs && h < hve && v >= vvs && v < vve));
        chk({nm, ".pix_en"},     pe,  int'((tc % d) == d - 1));
        chk({nm, ".frame_tick"}, ft,  int'(tc > 0 && (tc % (d * ht * vt)) == 0));
    endtask

    task automatic check_all();
        check_dut("def", 4, 800, 96, 144, 784, 525, 2, 35, 515,
                  int'(if_def.hCount), int'(if_def.vCount), int'(if_def.hSync),
                  int'(if_def.vSync), int'(if_def.bright), int'(if_def.pix_en),
                  int'(if_def.frame_tick));
        check_dut("sm", 3, 20, 3, 5, 17, 10, 2, 3, 8,
                  int'(if_sm.hCount), int'(if_sm.vCount), int'(if_sm.hSync),
                  int'(if_sm.vSync), int'(if_sm.bright), int'(if_sm.pix_en),
                  int'(if_sm.frame_tick));
        check_dut("d1", 1, 20, 3, 5, 17, 10, 2, 3, 8,
                  int'(if_d1.hCount), int'(if_d1.vCount), int'(if_d1.hSync),
                  int'(if_d1.vSync), int'(if_d1.bright), int'(if_d1.pix_en),
                  int'(if_d1.frame_tick));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        repeat (5) step();
        rst = 1'b0;
        // Two full lines of the default build plus many small-raster frames
        repeat (7000) step();
        for (int ep = 0; ep < 8; ep++) begin
            repeat ($urandom_range(1, 2500)) step();
            // Off-edge reset: outputs must clear before the next rising edge
            #2 rst = 1'b1;
            #1 check_all();
            repeat ($urandom_range(1, 5)) step();
            rst = 1'b0;
        end
        repeat (700) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
